// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph codes, segment bit positions and
// the {a,b,c,d,e,f,g,dp} active-high patterns used by the scan controller.
package seg_pkg;

  typedef logic [4:0] glyph_t;
  typedef logic [7:0] seg_pattern_t;

  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  localparam glyph_t GLYPH_0     = 5'd0;
  localparam glyph_t GLYPH_1     = 5'd1;
  localparam glyph_t GLYPH_2     = 5'd2;
  localparam glyph_t GLYPH_3     = 5'd3;
  localparam glyph_t GLYPH_4     = 5'd4;
  localparam glyph_t GLYPH_5     = 5'd5;
  localparam glyph_t GLYPH_6     = 5'd6;
  localparam glyph_t GLYPH_7     = 5'd7;
  localparam glyph_t GLYPH_8     = 5'd8;
  localparam glyph_t GLYPH_9     = 5'd9;
  localparam glyph_t GLYPH_A     = 5'd10;
  localparam glyph_t GLYPH_B     = 5'd11;
  localparam glyph_t GLYPH_C     = 5'd12;
  localparam glyph_t GLYPH_D     = 5'd13;
  localparam glyph_t GLYPH_E     = 5'd14;
  localparam glyph_t GLYPH_F     = 5'd15;
  localparam glyph_t GLYPH_UNDER = 5'd16;
  localparam glyph_t GLYPH_U     = 5'd17;
  localparam glyph_t GLYPH_L     = 5'd18;
  localparam glyph_t GLYPH_P     = 5'd19;
  localparam glyph_t GLYPH_DASH  = 5'd20;
  localparam glyph_t GLYPH_N     = 5'd21;
  localparam glyph_t GLYPH_O     = 5'd22;
  localparam glyph_t GLYPH_R     = 5'd23;
  localparam glyph_t GLYPH_BLANK = 5'd31;

  localparam seg_pattern_t PAT_0     = 8'hFC;
  localparam seg_pattern_t PAT_1     = 8'h60;
  localparam seg_pattern_t PAT_2     = 8'hDA;
  localparam seg_pattern_t PAT_3     = 8'hF2;
  localparam seg_pattern_t PAT_4     = 8'h66;
  localparam seg_pattern_t PAT_5     = 8'hB6;
  localparam seg_pattern_t PAT_6     = 8'hBE;
  localparam seg_pattern_t PAT_7     = 8'hE0;
  localparam seg_pattern_t PAT_8     = 8'hFE;
  localparam seg_pattern_t PAT_9     = 8'hF6;
  localparam seg_pattern_t PAT_A     = 8'hEE;
  localparam seg_pattern_t PAT_B     = 8'h3E;
  localparam seg_pattern_t PAT_C     = 8'h9C;
  localparam seg_pattern_t PAT_D     = 8'h7A;
  localparam seg_pattern_t PAT_E     = 8'h9E;
  localparam seg_pattern_t PAT_F     = 8'h8E;
  localparam seg_pattern_t PAT_UNDER = 8'h10;
  localparam seg_pattern_t PAT_U     = 8'h7C;
  localparam seg_pattern_t PAT_L     = 8'h1C;
  localparam seg_pattern_t PAT_P     = 8'hCE;
  localparam seg_pattern_t PAT_DASH  = 8'h02;
  localparam seg_pattern_t PAT_N     = 8'h2A;
  localparam seg_pattern_t PAT_O     = 8'h3A;
  localparam seg_pattern_t PAT_R     = 8'h0A;
  localparam seg_pattern_t PAT_BLANK = 8'h00;

endpackage

// File: rtl/scan_display_ctrl_if.sv
// Bundle between game/menu logic and the scan controller: digit content,
// display controls, and the tube-facing segment/select outputs.
interface scan_display_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                      en;
  logic [5*NUM_DIGITS-1:0]   glyphs;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic [2:0]                brightness;
  logic [7:0]                seg_74;
  logic [7:0]                seg_30;
  logic [NUM_DIGITS-1:0]     tub_sel;

  modport master (
    output en, glyphs, dp_mask, blink_mask, brightness,
    input  seg_74, seg_30, tub_sel
  );

  modport slave (
    input  en, glyphs, dp_mask, blink_mask, brightness,
    output seg_74, seg_30, tub_sel
  );
endinterface

// File: rtl/seven_seg_glyph_rom.sv
// Combinational glyph-code to segment-pattern lookup; dp bit always 0,
// unassigned codes render blank.
module seven_seg_glyph_rom
  import seg_pkg::*;
(
  input  glyph_t       code,
  output seg_pattern_t pattern
);

  always_comb begin
    pattern = PAT_BLANK;
    case (code)
      GLYPH_0:     pattern = PAT_0;
      GLYPH_1:     pattern = PAT_1;
      GLYPH_2:     pattern = PAT_2;
      GLYPH_3:     pattern = PAT_3;
      GLYPH_4:     pattern = PAT_4;
      GLYPH_5:     pattern = PAT_5;
      GLYPH_6:     pattern = PAT_6;
      GLYPH_7:     pattern = PAT_7;
      GLYPH_8:     pattern = PAT_8;
      GLYPH_9:     pattern = PAT_9;
      GLYPH_A:     pattern = PAT_A;
      GLYPH_B:     pattern = PAT_B;
      GLYPH_C:     pattern = PAT_C;
      GLYPH_D:     pattern = PAT_D;
      GLYPH_E:     pattern = PAT_E;
      GLYPH_F:     pattern = PAT_F;
      GLYPH_UNDER: pattern = PAT_UNDER;
      GLYPH_U:     pattern = PAT_U;
      GLYPH_L:     pattern = PAT_L;
      GLYPH_P:     pattern = PAT_P;
      GLYPH_DASH:  pattern = PAT_DASH;
      GLYPH_N:     pattern = PAT_N;
      GLYPH_O:     pattern = PAT_O;
      GLYPH_R:     pattern = PAT_R;
      default:     pattern = PAT_BLANK;
    endcase
  end

endmodule

// File: rtl/scan_display_ctrl.sv
// Multiplexed seven-segment scan controller: exact slot timing, frame-synchronous
// input capture, per-digit dp/blink, PWM brightness, two segment banks.
module scan_display_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 25000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  scan_display_ctrl_if.slave      bus
);

  localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
  localparam int unsigned DIG_W   = $clog2(NUM_DIGITS);
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SLOT_W-1:0]      slot_cnt;
  logic [DIG_W-1:0]       digit_idx;
  logic [FRAME_W-1:0]     frame_cnt;
  logic                   blink_phase;
  glyph_t                 shadow_glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  shadow_dp;
  logic [NUM_DIGITS-1:0]  shadow_blink;

  logic                   slot_end;
  logic                   frame_end;
  logic                   lit;
  logic                   visible;
  logic                   upper_bank;
  logic [31:0]            lit_limit;
  seg_pattern_t           rom_pattern;
  seg_pattern_t           pattern;
  logic [NUM_DIGITS-1:0]  onehot;

  assign slot_end  = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (digit_idx == DIG_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end)
        digit_idx <= (digit_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      if (frame_end) begin
        if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Inputs only land at the frame boundary so a digit never changes mid-scan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        shadow_glyph[i] <= GLYPH_BLANK;
      shadow_dp    <= '0;
      shadow_blink <= '0;
    end else if (frame_end) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        shadow_glyph[i] <= bus.glyphs[5*i +: 5];
      shadow_dp    <= bus.dp_mask;
      shadow_blink <= bus.blink_mask;
    end
  end

  seven_seg_glyph_rom u_rom (
    .code    (shadow_glyph[digit_idx]),
    .pattern (rom_pattern)
  );

  // Level 7 bypasses the compare so truncation of SCAN_DIV>>3 never dims full brightness
  always_comb begin
    lit_limit = (SCAN_DIV >> 3) * (32'(bus.brightness) + 32'd1);
    lit       = (bus.brightness == 3'd7) || (32'(slot_cnt) < lit_limit);
  end

  always_comb begin
    visible         = bus.en && lit && !(shadow_blink[digit_idx] && blink_phase);
    upper_bank      = (digit_idx >= DIG_W'(NUM_DIGITS / 2));
    pattern         = rom_pattern;
    pattern[SEG_DP] = shadow_dp[digit_idx];
    onehot          = NUM_DIGITS'(1) << digit_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.seg_74  <= '0;
      bus.seg_30  <= '0;
      bus.tub_sel <= '0;
    end else begin
      bus.tub_sel <= visible ? onehot : '0;
      bus.seg_74  <= (visible &&  upper_bank) ? pattern : '0;
      bus.seg_30  <= (visible && !upper_bank) ? pattern : '0;
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl with NUM_DIGITS=8, SCAN_DIV=16, BLINK_FRAMES=2.
module tb_scan_display_ctrl;

  localparam int unsigned ND = 8;
  localparam int unsigned SD = 16;
  localparam int unsigned BF = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  scan_display_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  scan_display_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned cyc;
    logic        en_next;
    logic [2:0]  br_next;
    logic [7:0]  tub;
    logic [7:0]  s74;
    logic [7:0]  s30;
  } vec_t;

  vec_t        tbl [$];
  int unsigned k;
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", nm, got, exp);
  endtask

  task automatic chk_out(input string nm, input logic [7:0] t, input logic [7:0] s74,
                         input logic [7:0] s30);
    chk({nm, ".tub_sel"}, bus.tub_sel, t);
    chk({nm, ".seg_74"},  bus.seg_74,  s74);
    chk({nm, ".seg_30"},  bus.seg_30,  s30);
  endtask

  // Advance to the sample point of output cycle 'target' (negedge after edge 'target')
  task automatic run_to(input int unsigned target);
    if (target <= k) begin
      n_total++;
      $display("FAIL run_to: target %0d not after current %0d", target, k);
    end else begin
      while (k < target) begin
        @(posedge clk);
        k++;
      end
      @(negedge clk);
    end
  endtask

  task automatic addv(input int unsigned c, input logic e, input logic [2:0] b,
                      input logic [7:0] t, input logic [7:0] s74, input logic [7:0] s30);
    vec_t v;
    v.cyc = c; v.en_next = e; v.br_next = b; v.tub = t; v.s74 = s74; v.s30 = s30;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      run_to(tbl[i].cyc);
      chk_out($sformatf("%s[%0d]@%0d", nm, i, tbl[i].cyc), tbl[i].tub, tbl[i].s74, tbl[i].s30);
      bus.en         = tbl[i].en_next;
      bus.brightness = tbl[i].br_next;
    end
    tbl.delete();
  endtask

  task automatic set_all(input logic [4:0] g);
    for (int i = 0; i < int'(ND); i++) bus.glyphs[5*i +: 5] = g;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    k   = 0;
  endtask

  task automatic count_lit(input string nm, input logic [2:0] b, input logic [7:0] exp);
    logic [7:0] n;
    n = '0;
    bus.brightness = b;
    for (int i = 0; i < int'(SD); i++) begin
      run_to(k + 1);
      if (bus.tub_sel != '0) n++;
    end
    chk(nm, n, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b1; bus.brightness = 3'd7; bus.dp_mask = '0; bus.blink_mask = '0;
    set_all(5'd8);

    // Reset state and first (blank) frame, then all-8 display
    @(negedge clk);
    @(negedge clk);
    chk_out("in_reset", 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    k   = 0;
    addv(1,   1, 7, 8'h01, 8'h00, 8'h00);
    addv(16,  1, 7, 8'h01, 8'h00, 8'h00);
    addv(17,  1, 7, 8'h02, 8'h00, 8'h00);
    addv(65,  1, 7, 8'h10, 8'h00, 8'h00);
    addv(128, 1, 7, 8'h80, 8'h00, 8'h00);
    addv(129, 1, 7, 8'h01, 8'h00, 8'hFE);
    addv(193, 1, 7, 8'h10, 8'hFE, 8'h00);
    addv(256, 1, 7, 8'h80, 8'hFE, 8'h00);
    run_tbl("all8");

    // Decimal point and mid-frame glyph change held off until next frame
    set_all(5'd8);
    bus.glyphs[4:0] = 5'd3;
    bus.dp_mask     = 8'h01;
    do_reset();
    addv(129, 1, 7, 8'h01, 8'h00, 8'hF3);
    run_tbl("dp_a");
    bus.glyphs[4:0] = 5'd7;
    addv(140, 1, 7, 8'h01, 8'h00, 8'hF3);
    addv(145, 1, 7, 8'h02, 8'h00, 8'hFE);
    addv(257, 1, 7, 8'h01, 8'h00, 8'hE1);
    addv(272, 1, 7, 8'h01, 8'h00, 8'hE1);
    run_tbl("dp_b");

    // PWM windows and live brightness changes
    set_all(5'd8);
    bus.dp_mask    = '0;
    bus.brightness = 3'd0;
    do_reset();
    addv(1,  1, 0, 8'h01, 8'h00, 8'h00);
    addv(2,  1, 0, 8'h01, 8'h00, 8'h00);
    addv(3,  1, 0, 8'h00, 8'h00, 8'h00);
    addv(16, 1, 0, 8'h00, 8'h00, 8'h00);
    addv(17, 1, 0, 8'h02, 8'h00, 8'h00);
    addv(18, 1, 0, 8'h02, 8'h00, 8'h00);
    addv(19, 1, 0, 8'h00, 8'h00, 8'h00);
    addv(32, 1, 3, 8'h00, 8'h00, 8'h00);
    addv(33, 1, 3, 8'h04, 8'h00, 8'h00);
    addv(40, 1, 3, 8'h04, 8'h00, 8'h00);
    addv(41, 1, 7, 8'h00, 8'h00, 8'h00);
    addv(42, 1, 6, 8'h04, 8'h00, 8'h00);
    addv(46, 1, 6, 8'h04, 8'h00, 8'h00);
    addv(47, 1, 0, 8'h00, 8'h00, 8'h00);
    run_tbl("pwm");
    run_to(48);
    count_lit("lit_cnt_b0", 3'd0, 8'd2);
    count_lit("lit_cnt_b3", 3'd3, 8'd8);
    count_lit("lit_cnt_b7", 3'd7, 8'd16);

    // Blink on digit 7: phase flips after every second frame wrap
    set_all(5'd8);
    bus.glyphs[39:35] = 5'd1;
    bus.blink_mask    = 8'h80;
    bus.brightness    = 3'd7;
    do_reset();
    addv(241, 1, 7, 8'h80, 8'h60, 8'h00);
    addv(353, 1, 7, 8'h40, 8'hFE, 8'h00);
    addv(369, 1, 7, 8'h00, 8'h00, 8'h00);
    addv(497, 1, 7, 8'h00, 8'h00, 8'h00);
    addv(625, 1, 7, 8'h80, 8'h60, 8'h00);
    addv(753, 1, 7, 8'h80, 8'h60, 8'h00);
    addv(881, 1, 7, 8'h00, 8'h00, 8'h00);
    run_tbl("blink");

    // Enable dropped for 40 cycles; counters keep running underneath
    set_all(5'd8);
    bus.blink_mask = '0;
    do_reset();
    addv(150, 0, 7, 8'h02, 8'h00, 8'hFE);
    addv(151, 0, 7, 8'h00, 8'h00, 8'h00);
    addv(170, 0, 7, 8'h00, 8'h00, 8'h00);
    addv(190, 1, 7, 8'h00, 8'h00, 8'h00);
    addv(191, 1, 7, 8'h08, 8'h00, 8'hFE);
    addv(192, 1, 7, 8'h08, 8'h00, 8'hFE);
    run_tbl("en");

    // Asynchronous reset mid-slot at digit 5, then blank first frame again
    do_reset();
    addv(215, 1, 7, 8'h20, 8'hFE, 8'h00);
    run_tbl("pre_rst");
    rst = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk_out("held_rst", 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    k   = 0;
    addv(1,   1, 7, 8'h01, 8'h00, 8'h00);
    addv(65,  1, 7, 8'h10, 8'h00, 8'h00);
    addv(128, 1, 7, 8'h80, 8'h00, 8'h00);
    addv(129, 1, 7, 8'h01, 8'h00, 8'hFE);
    run_tbl("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
